// File: rtl/mem_fill_arbiter_if.sv
// Memory-side bus of the fill arbiter: one pipelined port with in-order read returns.
// The arbiter drives requests (master); the main memory answers (slave).
interface mem_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_valid
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_valid
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shares one pipelined main memory between N_CH cache channels: write-through
// stores take one cycle, read misses stream a whole block into the data array.
module mem_fill_arbiter #(
  parameter int N_CH        = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LAT     = 4,
  parameter int RR_MODE     = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CH-1:0]                miss_req,
  input  logic [N_CH*ADDR_W-1:0]         miss_addr,
  input  logic [N_CH-1:0]                wr_req,
  input  logic [N_CH*ADDR_W-1:0]         wr_addr,
  input  logic [N_CH*DATA_W-1:0]         wr_data,
  output logic [N_CH-1:0]                busy,
  output logic [N_CH-1:0]                grant,
  output logic [N_CH-1:0]                fill_we,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [DATA_W-1:0]              fill_data,
  output logic [N_CH-1:0]                tag_we,
  output logic [N_CH-1:0]                done,
  mem_fill_arbiter_if.master             mem
);

  localparam int WB = $clog2(BLOCK_WORDS);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << (WB + 1);
  localparam logic [WB:0]       ISSUE_END = (WB + 1)'(BLOCK_WORDS);
  localparam logic [WB-1:0]     LAST_WORD = WB'(BLOCK_WORDS - 1);

  // The fill counters and the fixed latency model only make sense for these.
  if ((BLOCK_WORDS < 2) || ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) || (MEM_LAT < 1)) begin : g_param_check
    $error("mem_fill_arbiter: BLOCK_WORDS must be a power of 2 >= 2 and MEM_LAT >= 1");
  end

  typedef enum logic [1:0] {IDLE, WRITE, FILL, TAG} state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [WB:0]       issue_q, issue_d;
  logic [WB-1:0]     recv_q, recv_d;
  logic [CW-1:0]     rr_q, rr_d;

  logic [N_CH-1:0]   req;
  logic [CW-1:0]     search_base;
  logic [CW:0]       cand;
  logic [CW:0]       rr_step;
  logic [CW-1:0]     win_idx;
  logic              win_found;

  assign req   = miss_req | wr_req;
  assign grant = grant_q;
  assign busy  = req & ~done & {N_CH{rst_n}};

  // Winner search: fixed priority starts at channel 0, round-robin starts at
  // the channel after the last one granted (rr_q holds that next channel).
  always_comb begin
    search_base = (RR_MODE != 0) ? rr_q : '0;
    win_found   = 1'b0;
    win_idx     = '0;
    cand        = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = {1'b0, search_base} + (CW + 1)'(k);
      if (cand >= (CW + 1)'(N_CH)) cand = cand - (CW + 1)'(N_CH);
      if (!win_found && req[cand[CW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[CW-1:0];
      end
    end
    rr_step = {1'b0, win_idx} + 1'b1;
    if (rr_step >= (CW + 1)'(N_CH)) rr_step = '0;
  end

  // Next-state and output decode; everything defaults to 0 so IDLE and reset
  // present a quiet bus and per-channel strobes simply mirror the grant.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    data_d        = data_q;
    issue_d       = issue_q;
    recv_d        = recv_q;
    rr_d          = rr_q;
    fill_we       = '0;
    fill_word     = '0;
    fill_data     = '0;
    tag_we        = '0;
    done          = '0;
    mem.mem_en    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;

    case (state_q)
      IDLE: begin
        issue_d = '0;
        recv_d  = '0;
        grant_d = '0;
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          rr_d             = rr_step[CW-1:0];
          for (int c = 0; c < N_CH; c++) begin
            if (win_idx == CW'(c)) begin
              if (wr_req[c]) begin
                state_d = WRITE;
                addr_d  = wr_addr[c*ADDR_W +: ADDR_W];
                data_d  = wr_data[c*DATA_W +: DATA_W];
              end else begin
                state_d = FILL;
                addr_d  = miss_addr[c*ADDR_W +: ADDR_W] & BASE_MASK;
              end
            end
          end
        end
      end

      WRITE: begin
        mem.mem_en    = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = data_q;
        done          = grant_q;
        grant_d       = '0;
        state_d       = IDLE;
      end

      // Issue and receive run independently; returns are in order, so the
      // receive count alone identifies the word being written.
      FILL: begin
        if (issue_q < ISSUE_END) begin
          mem.mem_en   = 1'b1;
          mem.mem_addr = addr_q + (ADDR_W'(issue_q) << 1);
          issue_d      = issue_q + 1'b1;
        end
        if (mem.mem_valid) begin
          fill_we   = grant_q;
          fill_word = recv_q;
          fill_data = mem.mem_rdata;
          recv_d    = recv_q + 1'b1;
          if (recv_q == LAST_WORD) state_d = TAG;
        end
      end

      TAG: begin
        tag_we  = grant_q;
        done    = grant_q;
        grant_d = '0;
        state_d = IDLE;
      end

      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any fill so no tag write or done follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      issue_q <= '0;
      recv_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench: directed requests push cycle-stamped expected bus events,
// a negedge monitor pops and compares every event the arbiter presents.
module tb_mem_fill_arbiter;

  localparam int N_CH = 2;
  localparam int BW   = 8;
  localparam int LAT  = 4;

  localparam int K_MRD  = 0;
  localparam int K_MWR  = 1;
  localparam int K_FILL = 2;
  localparam int K_TAG  = 3;
  localparam int K_DONE = 4;

  typedef struct {
    int          cyc;
    int          kind;
    int          ch;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic spur_v = 1'b0;

  logic [1:0]  miss_req0 = '0, wr_req0 = '0;
  logic [31:0] miss_addr0 = '0, wr_addr0 = '0, wr_data0 = '0;
  logic [1:0]  busy0, grant0, fill_we0, tag_we0, done0;
  logic [2:0]  fill_word0;
  logic [15:0] fill_data0;

  logic [1:0]  miss_req1 = '0, wr_req1 = '0;
  logic [31:0] miss_addr1 = '0, wr_addr1 = '0, wr_data1 = '0;
  logic [1:0]  busy1, grant1, fill_we1, tag_we1, done1;
  logic [2:0]  fill_word1;
  logic [15:0] fill_data1;

  mem_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16)) mb0 ();
  mem_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16)) mb1 ();

  mem_fill_arbiter #(.N_CH(2), .ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(BW),
                     .MEM_LAT(LAT), .RR_MODE(0)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .miss_req(miss_req0), .miss_addr(miss_addr0),
    .wr_req(wr_req0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .grant(grant0), .fill_we(fill_we0),
    .fill_word(fill_word0), .fill_data(fill_data0),
    .tag_we(tag_we0), .done(done0), .mem(mb0)
  );

  mem_fill_arbiter #(.N_CH(2), .ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(BW),
                     .MEM_LAT(LAT), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .miss_req(miss_req1), .miss_addr(miss_addr1),
    .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .grant(grant1), .fill_we(fill_we1),
    .fill_word(fill_word1), .fill_data(fill_data1),
    .tag_we(tag_we1), .done(done1), .mem(mb1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Memory models: a read accepted in cycle k returns in cycle k+LAT.
  logic [LAT-1:0] v0, v1;
  logic [15:0]    a0 [LAT];
  logic [15:0]    a1 [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= '0;
      v1 <= '0;
      for (int i = 0; i < LAT; i++) begin
        a0[i] <= '0;
        a1[i] <= '0;
      end
    end else begin
      v0    <= {v0[LAT-2:0], mb0.mem_en & ~mb0.mem_wr};
      v1    <= {v1[LAT-2:0], mb1.mem_en & ~mb1.mem_wr};
      a0[0] <= mb0.mem_addr;
      a1[0] <= mb1.mem_addr;
      for (int i = 1; i < LAT; i++) begin
        a0[i] <= a0[i-1];
        a1[i] <= a1[i-1];
      end
    end
  end

  assign mb0.mem_valid = v0[LAT-1] | spur_v;
  assign mb0.mem_rdata = v0[LAT-1] ? mdata(a0[LAT-1]) : (spur_v ? 16'h5555 : 16'h0000);
  assign mb1.mem_valid = v1[LAT-1];
  assign mb1.mem_rdata = v1[LAT-1] ? mdata(a1[LAT-1]) : 16'h0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic checkEvent(input ev_t act);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL event: got cyc=%0d kind=%0d ch=%0d a=0x%0h d=0x%0h, expected none",
               act.cyc, act.kind, act.ch, act.a, act.d);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != act.cyc || e.kind != act.kind || e.ch != act.ch || e.a !== act.a || e.d !== act.d) begin
        miscompares++;
        $display("[TB] FAIL event: got cyc=%0d kind=%0d ch=%0d a=0x%0h d=0x%0h, expected cyc=%0d kind=%0d ch=%0d a=0x%0h d=0x%0h",
                 act.cyc, act.kind, act.ch, act.a, act.d, e.cyc, e.kind, e.ch, e.a, e.d);
      end
    end
  endtask

  task automatic pushEv(input int c, input int kind, input int ch, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e = '{c, kind, ch, a, d};
    exp_q.push_back(e);
  endtask

  // Expected fill from FILL entry at cycle t, truncated at cycle lim.
  task automatic pushFill(input int ch, input logic [15:0] base, input int t, input int lim);
    for (int k = t; k <= lim; k++) begin
      int i;
      int r;
      i = k - t;
      r = k - t - LAT;
      if (i < BW) pushEv(k, K_MRD, 0, base + 16'(2 * i), 16'h0000);
      if (r >= 0 && r < BW) pushEv(k, K_FILL, ch, 16'(r), mdata(base + 16'(2 * r)));
      if (k == t + BW + LAT) begin
        pushEv(k, K_TAG, ch, 16'h0, 16'h0);
        pushEv(k, K_DONE, ch, 16'h0, 16'h0);
      end
    end
  endtask

  task automatic applyStimulus(input int ch, input bit is_wr, input logic [15:0] addr, input logic [15:0] data);
    if (is_wr) begin
      wr_addr0[ch*16 +: 16] = addr;
      wr_data0[ch*16 +: 16] = data;
      wr_req0[ch]           = 1'b1;
    end else begin
      miss_addr0[ch*16 +: 16] = addr;
      miss_req0[ch]           = 1'b1;
    end
  endtask

  task automatic releaseReq(input int ch);
    miss_req0[ch] = 1'b0;
    wr_req0[ch]   = 1'b0;
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every strobe on the fixed-priority arbiter is one event.
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (mb0.mem_en === 1'b1) begin
        ev = '{cyc, (mb0.mem_wr === 1'b1) ? K_MWR : K_MRD, 0, mb0.mem_addr,
               (mb0.mem_wr === 1'b1) ? mb0.mem_wdata : 16'h0000};
        checkEvent(ev);
      end
      for (int c = 0; c < N_CH; c++)
        if (fill_we0[c] === 1'b1) begin
          ev = '{cyc, K_FILL, c, {13'b0, fill_word0}, fill_data0};
          checkEvent(ev);
        end
      for (int c = 0; c < N_CH; c++)
        if (tag_we0[c] === 1'b1) begin
          ev = '{cyc, K_TAG, c, 16'h0, 16'h0};
          checkEvent(ev);
        end
      for (int c = 0; c < N_CH; c++)
        if (done0[c] === 1'b1) begin
          ev = '{cyc, K_DONE, c, 16'h0, 16'h0};
          checkEvent(ev);
        end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] seen [4];
    logic [1:0] rr_exp [4];
    logic [1:0] prev;
    int         nseen;

    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    prev   = 2'b00;
    nseen  = 0;
    foreach (seen[i]) seen[i] = 2'b00;

    $display("[TB] reset state");
    goto(1); #3;
    checkOutput("reset_grant", grant0, 2'b00);
    checkOutput("reset_mem_en", mb0.mem_en, 1'b0);
    checkOutput("reset_done", done0, 2'b00);
    goto(3);
    rst_n = 1'b1;
    goto(4); #3;
    checkOutput("idle_grant", grant0, 2'b00);
    checkOutput("idle_busy", busy0, 2'b00);

    $display("[TB] single miss ch0 at 0x1234");
    goto(5);
    applyStimulus(0, 1'b0, 16'h1234, 16'h0000);
    pushFill(0, 16'h1230, 6, 18);
    goto(6); #3;
    checkOutput("miss_grant", grant0, 2'b01);
    goto(17); #3;
    checkOutput("miss_busy_before_done", busy0[0], 1'b1);
    goto(18); #3;
    checkOutput("miss_busy_in_done", busy0[0], 1'b0);
    goto(19);
    releaseReq(0);

    $display("[TB] write-through ch1");
    goto(21);
    applyStimulus(1, 1'b1, 16'h0040, 16'hBEEF);
    pushEv(22, K_MWR, 0, 16'h0040, 16'hBEEF);
    pushEv(22, K_DONE, 1, 16'h0, 16'h0);
    goto(22); #3;
    checkOutput("write_grant", grant0, 2'b10);
    checkOutput("write_busy", busy0[1], 1'b0);
    goto(23);
    releaseReq(1);

    $display("[TB] spurious mem_valid in IDLE");
    goto(25);
    spur_v = 1'b1;
    goto(26);
    spur_v = 1'b0;

    $display("[TB] fixed priority, both channels miss");
    goto(28);
    applyStimulus(0, 1'b0, 16'h2000, 16'h0000);
    applyStimulus(1, 1'b0, 16'h3458, 16'h0000);
    pushFill(0, 16'h2000, 29, 41);
    pushFill(1, 16'h3450, 43, 55);
    for (int k = 29; k <= 41; k++) begin
      goto(k); #3;
      checkOutput($sformatf("prio_busy1_c%0d", k), busy0[1], 1'b1);
    end
    goto(42);
    releaseReq(0);
    #3;
    checkOutput("prio_grant_gap", grant0, 2'b00);
    goto(43); #3;
    checkOutput("prio_grant_ch1", grant0, 2'b10);
    goto(56);
    releaseReq(1);

    $display("[TB] reset during fill");
    goto(58);
    applyStimulus(0, 1'b0, 16'h4A6C, 16'h0000);
    pushFill(0, 16'h4A60, 59, 66);
    goto(66); #6;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_grant", grant0, 2'b00);
    checkOutput("rst_busy", busy0, 2'b00);
    checkOutput("rst_fill_we", fill_we0, 2'b00);
    checkOutput("rst_tag_we", tag_we0, 2'b00);
    checkOutput("rst_done", done0, 2'b00);
    checkOutput("rst_mem_en", {mb0.mem_en, mb0.mem_wr}, 2'b00);
    checkOutput("rst_mem_addr", mb0.mem_addr, 16'h0000);
    checkOutput("rst_fill_word", fill_word0, 3'd0);
    checkOutput("rst_fill_data", fill_data0, 16'h0000);
    goto(69);
    rst_n = 1'b1;
    pushFill(0, 16'h4A60, 70, 82);
    goto(83);
    releaseReq(0);

    $display("[TB] round-robin, both channels re-requesting");
    goto(88);
    miss_addr1 = {16'h0200, 16'h0100};
    miss_req1  = 2'b11;
    for (int k = 89; k < 169 && nseen < 4; k++) begin
      goto(k); #3;
      if (grant1 != 2'b00 && prev == 2'b00) begin
        seen[nseen] = grant1;
        nseen++;
      end
      prev = grant1;
    end
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("rr_grant_%0d", i), (i < nseen) ? seen[i] : 2'b00, rr_exp[i]);
    miss_req1 = 2'b00;

    goto(170); #3;
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
